// File: rtl/ninja_pkg.sv
// Shared types and constants for the reflex-game sequencer.
package ninja_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    WAIT,
    GAP,
    OVER,
    WIN
  } state_t;

  localparam logic [3:0] ACT_NONE  = 4'hF;
  localparam logic [2:0] LVL_IDLE  = 3'd0;
  localparam logic [2:0] LVL_WON   = 3'd4;
  localparam logic [2:0] LVL_LAST  = 3'd3;
  localparam logic [2:0] WRONG_MAX = 3'd3;

  // One step of the 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1 (right-shift form).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

endpackage

// File: rtl/ninja_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, cleared only by rst.
module ninja_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and pulse tick on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ninja_game_ctrl.sv
// Reflex-game sequencer: draws actions, times the response window, judges presses.
module ninja_game_ctrl
  import ninja_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ROUNDS    = 8,
  parameter int unsigned WIN_L1    = 1500,
  parameter int unsigned WIN_L2    = 1000,
  parameter int unsigned WIN_L3    = 600,
  parameter int unsigned GAP_TICKS = 500,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [2:0] level,
  output logic [2:0] wrong_time,
  output logic [3:0] action,
  output logic [3:0] operation,
  output logic       game_over,
  output logic       win
);

  state_t      state, state_next;
  logic [2:0]  level_q, level_n, wrong_q, wrong_n;
  logic [3:0]  action_q, action_n, operation_q, operation_n;
  logic [3:0]  round_q, round_n;
  logic [15:0] win_cnt_q, win_cnt_n, gap_cnt_q, gap_cnt_n;
  logic        start_q;
  logic [3:0]  btn_q;
  logic [7:0]  lfsr;
  logic        tick;

  logic        start_rise;
  logic [3:0]  btn_rise;
  logic        multi;
  logic [1:0]  low_code;
  logic [15:0] window;
  logic        judge_ok, judge_bad;
  logic [4:0]  round_inc;

  assign start_rise = start & ~start_q;
  assign btn_rise   = btn & ~btn_q;

  ninja_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Edge-detect registers and free-running LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      btn_q   <= '0;
      lfsr    <= SEED;
    end else begin
      start_q <= start;
      btn_q   <= btn;
      lfsr    <= lfsr_step(lfsr);
    end
  end

  // State register plus the game datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      level_q     <= LVL_IDLE;
      wrong_q     <= '0;
      action_q    <= ACT_NONE;
      operation_q <= ACT_NONE;
      round_q     <= '0;
      win_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state       <= state_next;
      level_q     <= level_n;
      wrong_q     <= wrong_n;
      action_q    <= action_n;
      operation_q <= operation_n;
      round_q     <= round_n;
      win_cnt_q   <= win_cnt_n;
      gap_cnt_q   <= gap_cnt_n;
    end
  end

  // Next state and datapath: judging is folded into the WAIT edge so results land with zero latency.
  always_comb begin
    state_next  = state;
    level_n     = level_q;
    wrong_n     = wrong_q;
    action_n    = action_q;
    operation_n = operation_q;
    round_n     = round_q;
    win_cnt_n   = win_cnt_q;
    gap_cnt_n   = gap_cnt_q;
    judge_ok    = 1'b0;
    judge_bad   = 1'b0;
    round_inc   = {1'b0, round_q} + 5'd1;
    multi       = |(btn_rise & (btn_rise - 4'd1));

    if (btn_rise[0])      low_code = 2'd0;
    else if (btn_rise[1]) low_code = 2'd1;
    else if (btn_rise[2]) low_code = 2'd2;
    else                  low_code = 2'd3;

    case (level_q)
      3'd1:    window = 16'(WIN_L1);
      3'd2:    window = 16'(WIN_L2);
      default: window = 16'(WIN_L3);
    endcase

    case (state)
      IDLE, OVER, WIN: begin
        if (start_rise) begin
          level_n    = 3'd1;
          wrong_n    = '0;
          round_n    = '0;
          state_next = SHOW;
        end
      end
      SHOW: begin
        action_n    = {2'b00, lfsr[1:0]};
        operation_n = ACT_NONE;
        win_cnt_n   = window;
        state_next  = WAIT;
      end
      WAIT: begin
        if (|btn_rise) begin
          operation_n = {2'b00, low_code};
          if (!multi && (low_code == action_q[1:0])) judge_ok = 1'b1;
          else judge_bad = 1'b1;
        end else if (tick) begin
          if (win_cnt_q <= 16'd1) judge_bad = 1'b1;
          else win_cnt_n = win_cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q <= 16'd1) state_next = SHOW;
          else gap_cnt_n = gap_cnt_q - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (judge_bad) begin
      wrong_n = wrong_q + 3'd1;
      if (wrong_n == WRONG_MAX) begin
        action_n   = ACT_NONE;
        state_next = OVER;
      end else begin
        gap_cnt_n  = 16'(GAP_TICKS);
        state_next = GAP;
      end
    end

    if (judge_ok) begin
      if (round_inc == 5'(ROUNDS)) begin
        if (level_q == LVL_LAST) begin
          level_n    = LVL_WON;
          action_n   = ACT_NONE;
          state_next = WIN;
        end else begin
          level_n    = level_q + 3'd1;
          round_n    = '0;
          gap_cnt_n  = 16'(GAP_TICKS);
          state_next = GAP;
        end
      end else begin
        round_n    = round_inc[3:0];
        gap_cnt_n  = 16'(GAP_TICKS);
        state_next = GAP;
      end
    end
  end

  // Outputs: flags decode the state, the rest come straight from registers.
  always_comb begin
    game_over  = (state == OVER);
    win        = (state == WIN);
    level      = level_q;
    wrong_time = wrong_q;
    action     = action_q;
    operation  = operation_q;
  end

endmodule
